// File: rtl/hazard_stall_ctrl.sv
// Stall/flush control for ID-stage hazards that forwarding cannot cover.
// Ports: ID/EX/MEM operand info in; PC/IF_ID enables, bubble, flush, stall count out.
module hazard_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_Rs1,
  input  logic [4:0]       IF_ID_Rs2,
  input  logic             IF_ID_UsesRs1,
  input  logic             IF_ID_UsesRs2,
  input  logic             IF_ID_Branch,
  input  logic             IF_ID_MemWrite,
  input  logic             BranchTaken,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       EX_MEM_Rd,
  input  logic             EX_MEM_MemRead,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_CtrlZero,
  output logic             IF_ID_Flush,
  output logic [CNT_W-1:0] StallCycles
);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_ex_m1;
  logic w_ex_m2;
  logic w_mem_m;
  logic w_lu;
  logic w_ba;
  logic w_bl;
  logic w_need1;
  logic w_need2;
  logic w_idle;
  logic w_stall;

  always_comb begin
    w_ex_m1 = (ID_EX_Rd != 5'd0) && IF_ID_UsesRs1
            && (ID_EX_Rd == IF_ID_Rs1);
    w_ex_m2 = (ID_EX_Rd != 5'd0) && IF_ID_UsesRs2
            && (ID_EX_Rd == IF_ID_Rs2);
    w_mem_m = (EX_MEM_Rd != 5'd0)
            && ((IF_ID_UsesRs1 && (EX_MEM_Rd == IF_ID_Rs1))
             || (IF_ID_UsesRs2 && (EX_MEM_Rd == IF_ID_Rs2)));
  end

  // A store only needs the loaded value as data (rs2) in MEM, where
  // load->store forwarding supplies it, so an rs2-only match is no hazard.
  assign w_lu = ID_EX_MemRead
              && (w_ex_m1 || (w_ex_m2 && !IF_ID_MemWrite));
  assign w_ba = IF_ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead
              && (w_ex_m1 || w_ex_m2);
  assign w_bl = IF_ID_Branch && EX_MEM_MemRead && w_mem_m;

  assign w_need2 = w_lu && IF_ID_Branch;
  assign w_need1 = (w_lu || w_ba || w_bl) && !w_need2;

  assign w_idle  = (r_state == S_IDLE);
  assign w_stall = (w_idle && (w_need1 || w_need2))
                 || (r_state == S_HOLD);

  // Reset overrides the enables directly so they react asynchronously.
  assign PCWrite        = !rst && !w_stall;
  assign IF_ID_Write    = !rst && !w_stall;
  assign ID_EX_CtrlZero = rst || w_stall;
  // Compare result uses stale operands while stalled; mask it.
  assign IF_ID_Flush    = !rst && BranchTaken && IF_ID_Branch
                        && !w_stall;
  assign StallCycles    = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: r_state <= w_need2 ? S_HOLD : S_IDLE;
        S_HOLD: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_stall && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios
// plus randomized inputs against a rule-level reference model.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd, EX_MEM_Rd;
  logic       IF_ID_UsesRs1, IF_ID_UsesRs2, IF_ID_Branch;
  logic       IF_ID_MemWrite, BranchTaken;
  logic       ID_EX_RegWrite, ID_EX_MemRead, EX_MEM_MemRead;
  logic       PCWrite, IF_ID_Write, ID_EX_CtrlZero, IF_ID_Flush;
  logic [15:0] StallCycles;
  logic       PCWrite2, IF_ID_Write2, ID_EX_CtrlZero2, IF_ID_Flush2;
  logic [1:0] StallCycles2;
  logic [3:0] vec;

  int     total = 0;
  int     bad   = 0;
  int     m_hold;
  longint m_stalls;

  always #5 clk = ~clk;

  assign vec = {PCWrite, IF_ID_Write, ID_EX_CtrlZero, IF_ID_Flush};

  hazard_stall_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2),
    .IF_ID_UsesRs1(IF_ID_UsesRs1), .IF_ID_UsesRs2(IF_ID_UsesRs2),
    .IF_ID_Branch(IF_ID_Branch), .IF_ID_MemWrite(IF_ID_MemWrite),
    .BranchTaken(BranchTaken), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_MemRead(EX_MEM_MemRead),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .ID_EX_CtrlZero(ID_EX_CtrlZero), .IF_ID_Flush(IF_ID_Flush),
    .StallCycles(StallCycles)
  );

  hazard_stall_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2),
    .IF_ID_UsesRs1(IF_ID_UsesRs1), .IF_ID_UsesRs2(IF_ID_UsesRs2),
    .IF_ID_Branch(IF_ID_Branch), .IF_ID_MemWrite(IF_ID_MemWrite),
    .BranchTaken(BranchTaken), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_MemRead(EX_MEM_MemRead),
    .PCWrite(PCWrite2), .IF_ID_Write(IF_ID_Write2),
    .ID_EX_CtrlZero(ID_EX_CtrlZero2), .IF_ID_Flush(IF_ID_Flush2),
    .StallCycles(StallCycles2)
  );

  // Reads register r for the ID instruction (rs2 optionally ignored).
  function automatic bit reads(input logic [4:0] r, input bit rs1_only);
    if (r == 5'd0) return 1'b0;
    if (IF_ID_UsesRs1 && r == IF_ID_Rs1) return 1'b1;
    if (!rs1_only && IF_ID_UsesRs2 && r == IF_ID_Rs2) return 1'b1;
    return 1'b0;
  endfunction

  // 0 = no hazard, 1 = one stall cycle, 2 = two stall cycles.
  function automatic int hazard_len();
    bit lu, ba, bl;
    lu = ID_EX_MemRead && reads(ID_EX_Rd, IF_ID_MemWrite);
    ba = IF_ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead
       && reads(ID_EX_Rd, 1'b0);
    bl = IF_ID_Branch && EX_MEM_MemRead && reads(EX_MEM_Rd, 1'b0);
    if (lu && IF_ID_Branch) return 2;
    if (lu || ba || bl) return 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    return (m_hold != 0) || (hazard_len() != 0);
  endfunction

  function automatic logic [3:0] exp_vec();
    if (rst) return 4'b0010;
    if (exp_stall()) return 4'b0010;
    return {1'b1, 1'b1, 1'b0, BranchTaken & IF_ID_Branch};
  endfunction

  task automatic clear_inputs();
    IF_ID_Rs1 = 0; IF_ID_Rs2 = 0; ID_EX_Rd = 0; EX_MEM_Rd = 0;
    IF_ID_UsesRs1 = 0; IF_ID_UsesRs2 = 0; IF_ID_Branch = 0;
    IF_ID_MemWrite = 0; BranchTaken = 0; ID_EX_RegWrite = 0;
    ID_EX_MemRead = 0; EX_MEM_MemRead = 0;
  endtask

  // Advance one clock; the model consumes the inputs seen at the edge.
  task automatic tick();
    bit s;
    int h;
    @(posedge clk);
    if (!rst) begin
      s = exp_stall();
      h = hazard_len();
      if (s) m_stalls++;
      m_hold = (m_hold == 0 && h == 2) ? 1 : 0;
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    m_hold = 0;
    m_stalls = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    m_hold = 0;
    m_stalls = 0;
    @(negedge clk);
    total++;
    if (vec !== 4'b0010) begin
      bad++; $display("FAIL rst_outs got=%b want=0010", vec);
    end
    total++;
    if (StallCycles !== 16'd0 || StallCycles2 !== 2'd0) begin
      bad++; $display("FAIL rst_cnt got=%0d/%0d want=0", StallCycles, StallCycles2);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (vec !== 4'b1100) begin
      bad++; $display("FAIL rst_rel got=%b want=1100", vec);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_Rd = 5;
    IF_ID_Rs1 = 5; IF_ID_UsesRs1 = 1;
    @(negedge clk);
    total++;
    if (vec !== 4'b0010) begin
      bad++; $display("FAIL lu_stall got=%b want=0010", vec);
    end
    tick();
    ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_Rd = 0;
    EX_MEM_Rd = 5; EX_MEM_MemRead = 1;
    @(negedge clk);
    total++;
    if (vec !== 4'b1100) begin
      bad++; $display("FAIL lu_bubble got=%b want=1100", vec);
    end
    tick();
    total++;
    if (StallCycles !== 16'd1) begin
      bad++; $display("FAIL lu_cnt got=%0d want=1", StallCycles);
    end
  endtask

  task automatic test_store_fwd();
    do_reset();
    ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_Rd = 6;
    IF_ID_MemWrite = 1; IF_ID_Rs1 = 2; IF_ID_Rs2 = 6;
    IF_ID_UsesRs1 = 1; IF_ID_UsesRs2 = 1;
    @(negedge clk);
    total++;
    if (vec !== 4'b1100) begin
      bad++; $display("FAIL st_rs2 got=%b want=1100", vec);
    end
    tick();
    IF_ID_Rs1 = 6;
    @(negedge clk);
    total++;
    if (vec !== 4'b0010) begin
      bad++; $display("FAIL st_rs1 got=%b want=0010", vec);
    end
    tick();
    total++;
    if (StallCycles !== 16'd1) begin
      bad++; $display("FAIL st_cnt got=%0d want=1", StallCycles);
    end
  endtask

  task automatic test_load_branch();
    do_reset();
    ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_Rd = 7;
    IF_ID_Branch = 1; BranchTaken = 1;
    IF_ID_Rs1 = 7; IF_ID_Rs2 = 1; IF_ID_UsesRs1 = 1; IF_ID_UsesRs2 = 1;
    @(negedge clk);
    total++;
    if (vec !== 4'b0010) begin
      bad++; $display("FAIL lb_c1 got=%b want=0010", vec);
    end
    tick();
    ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_Rd = 0;
    EX_MEM_Rd = 7; EX_MEM_MemRead = 1;
    @(negedge clk);
    total++;
    if (vec !== 4'b0010) begin
      bad++; $display("FAIL lb_c2 got=%b want=0010", vec);
    end
    tick();
    EX_MEM_Rd = 0; EX_MEM_MemRead = 0;
    @(negedge clk);
    total++;
    if (vec !== 4'b1101) begin
      bad++; $display("FAIL lb_c3 got=%b want=1101", vec);
    end
    total++;
    if (StallCycles !== 16'd2) begin
      bad++; $display("FAIL lb_cnt got=%0d want=2", StallCycles);
    end
    tick();
  endtask

  task automatic test_alu_branch();
    do_reset();
    ID_EX_RegWrite = 1; ID_EX_Rd = 8;
    IF_ID_Branch = 1; BranchTaken = 1;
    IF_ID_Rs1 = 3; IF_ID_Rs2 = 8; IF_ID_UsesRs1 = 1; IF_ID_UsesRs2 = 1;
    @(negedge clk);
    total++;
    if (vec !== 4'b0010) begin
      bad++; $display("FAIL ab_stall got=%b want=0010", vec);
    end
    tick();
    ID_EX_RegWrite = 0;
    @(negedge clk);
    total++;
    if (vec !== 4'b1101) begin
      bad++; $display("FAIL ab_after got=%b want=1101", vec);
    end
    tick();
    ID_EX_RegWrite = 1; ID_EX_Rd = 0; IF_ID_Rs2 = 0;
    @(negedge clk);
    total++;
    if (vec !== 4'b1101) begin
      bad++; $display("FAIL ab_x0 got=%b want=1101", vec);
    end
    total++;
    if (StallCycles !== 16'd1) begin
      bad++; $display("FAIL ab_cnt got=%0d want=1", StallCycles);
    end
    tick();
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_Rd = 7;
    IF_ID_Branch = 1; IF_ID_Rs1 = 7; IF_ID_UsesRs1 = 1;
    tick();
    clear_inputs();
    @(negedge clk);
    total++;
    if (vec !== 4'b0010) begin
      bad++; $display("FAIL rh_hold got=%b want=0010", vec);
    end
    #1 rst = 1'b1;
    m_hold = 0;
    m_stalls = 0;
    #1;
    total++;
    if (vec !== 4'b0010 || StallCycles !== 16'd0) begin
      bad++; $display("FAIL rh_async got=%b/%0d want=0010/0", vec, StallCycles);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (vec !== 4'b1100 || StallCycles !== 16'd0) begin
      bad++; $display("FAIL rh_idle got=%b/%0d want=1100/0", vec, StallCycles);
    end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_Rd = 5;
    IF_ID_Rs1 = 5; IF_ID_UsesRs1 = 1;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (StallCycles2 !== 2'd3 || StallCycles !== 16'd5) begin
      bad++; $display("FAIL sat_5 got=%0d/%0d want=3/5", StallCycles2, StallCycles);
    end
    tick();
    total++;
    if (StallCycles2 !== 2'd3) begin
      bad++; $display("FAIL sat_hold got=%0d want=3", StallCycles2);
    end
  endtask

  task automatic test_random();
    longint e16, e2;
    logic [3:0] ev;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      IF_ID_Rs1      = 5'($urandom_range(0, 3));
      IF_ID_Rs2      = 5'($urandom_range(0, 3));
      ID_EX_Rd       = 5'($urandom_range(0, 3));
      EX_MEM_Rd      = 5'($urandom_range(0, 3));
      IF_ID_UsesRs1  = 1'($urandom);
      IF_ID_UsesRs2  = 1'($urandom);
      IF_ID_Branch   = 1'($urandom);
      IF_ID_MemWrite = 1'($urandom);
      BranchTaken    = 1'($urandom);
      ID_EX_RegWrite = 1'($urandom);
      ID_EX_MemRead  = ($urandom_range(0, 2) == 0);
      EX_MEM_MemRead = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      ev  = exp_vec();
      e16 = (m_stalls > 65535) ? 65535 : m_stalls;
      e2  = (m_stalls > 3) ? 3 : m_stalls;
      total++;
      if (vec !== ev) begin
        bad++; $display("FAIL rnd_outs n=%0d got=%b want=%b", n, vec, ev);
      end
      total++;
      if (StallCycles !== 16'(e16) || StallCycles2 !== 2'(e2)) begin
        bad++;
        $display("FAIL rnd_cnt n=%0d got=%0d/%0d want=%0d/%0d",
                 n, StallCycles, StallCycles2, e16, e2);
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_store_fwd();
    test_load_branch();
    test_alu_branch();
    test_reset_in_hold();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
